// File: rtl/clk_display_mux.sv
// rtl/clk_display_mux.sv - multiplexed 4-digit seven-segment driver with adjust blink and colon
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank slot 3 when the tens-of-minutes digit is zero)
module clk_display_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min_ten,
    input  logic [3:0] min_one,
    input  logic [3:0] sec_ten,
    input  logic [3:0] sec_one,
    input  logic       adj_min,
    input  logic       adj_sec,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] r_ref_cnt;
    logic [1:0]    r_slot;
    logic [BW-1:0] r_frame_cnt;
    logic          r_blink_on;
    logic [3:0]    r_snap_min_ten;
    logic [3:0]    r_snap_min_one;
    logic [3:0]    r_snap_sec_ten;
    logic [3:0]    r_snap_sec_one;
    logic          r_snap_adj_min;
    logic          r_snap_adj_sec;
    logic          r_snap_blink;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_ref_wrap;
    logic          w_frame_start;
    logic [3:0]    w_digit;
    logic [6:0]    w_decoded;
    logic          w_blank;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    assign w_ref_wrap    = (r_ref_cnt == RW'(REFRESH_DIV - 1));
    assign w_frame_start = (r_ref_cnt == '0) && (r_slot == 2'd0);

    always_comb begin
        w_digit = r_snap_sec_one;
        case (r_slot)
            2'd0: w_digit = r_snap_sec_one;
            2'd1: w_digit = r_snap_sec_ten;
            2'd2: w_digit = r_snap_min_one;
            2'd3: w_digit = r_snap_min_ten;
            default: w_digit = r_snap_sec_one;
        endcase
    end

    always_comb begin
        w_decoded = 7'b0111111;
        case (w_digit)
            4'd0: w_decoded = 7'b1000000;
            4'd1: w_decoded = 7'b1111001;
            4'd2: w_decoded = 7'b0100100;
            4'd3: w_decoded = 7'b0110000;
            4'd4: w_decoded = 7'b0011001;
            4'd5: w_decoded = 7'b0010010;
            4'd6: w_decoded = 7'b0000010;
            4'd7: w_decoded = 7'b1111000;
            4'd8: w_decoded = 7'b0000000;
            4'd9: w_decoded = 7'b0010000;
            default: w_decoded = 7'b0111111;
        endcase
    end

    // Blink phase is taken from the frame-start snapshot so a frame is never half blanked.
    always_comb begin
        w_blank = !r_snap_blink &&
                  ((r_slot[1] && r_snap_adj_min) || (!r_slot[1] && r_snap_adj_sec));
`ifdef LEADING_ZERO_BLANK_EN
        if (r_slot == 2'd3 && r_snap_min_ten == 4'd0) begin
            w_blank = 1'b1;
        end
`endif
    end

    // Ghost cycle at ref_cnt=0 keeps every anode off while the slot changes.
    always_comb begin
        w_an  = 4'b1111;
        w_seg = 7'b1111111;
        w_dp  = 1'b1;
        if (r_ref_cnt != '0) begin
            w_an  = ~(4'b0001 << r_slot);
            w_seg = w_blank ? 7'b1111111 : w_decoded;
            w_dp  = (r_slot == 2'd2) ? 1'b0 : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref_cnt      <= '0;
            r_slot         <= 2'd0;
            r_frame_cnt    <= '0;
            r_blink_on     <= 1'b1;
            r_snap_min_ten <= 4'd0;
            r_snap_min_one <= 4'd0;
            r_snap_sec_ten <= 4'd0;
            r_snap_sec_one <= 4'd0;
            r_snap_adj_min <= 1'b0;
            r_snap_adj_sec <= 1'b0;
            r_snap_blink   <= 1'b1;
            r_an           <= 4'b1111;
            r_seg          <= 7'b1111111;
            r_dp           <= 1'b1;
        end else begin
            r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
            if (w_ref_wrap) begin
                r_slot <= r_slot + 2'd1;
            end
            if (w_frame_start) begin
                r_snap_min_ten <= min_ten;
                r_snap_min_one <= min_one;
                r_snap_sec_ten <= sec_ten;
                r_snap_sec_one <= sec_one;
                r_snap_adj_min <= adj_min;
                r_snap_adj_sec <= adj_sec;
                r_snap_blink   <= r_blink_on;
                if (r_frame_cnt == BW'(BLINK_DIV - 1)) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
